// File: rtl/dma_mem_arbiter_if.sv
// Bus bundle between the per-lane DMA engines, the lane arbiter and the PE memory port.
// The slave modport is the arbiter's view; master is the DMA/memory environment around it.
interface dma_mem_arbiter_if #(
  parameter int NUM_LANES  = 4,
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_LANES-1:0]            dma__memc__write_valid;
  logic [NUM_LANES*ADDR_WIDTH-1:0] dma__memc__write_address;
  logic [NUM_LANES*DATA_WIDTH-1:0] dma__memc__write_data;
  logic [NUM_LANES-1:0]            dma__memc__read_valid;
  logic [NUM_LANES*ADDR_WIDTH-1:0] dma__memc__read_address;
  logic [NUM_LANES-1:0]            dma__memc__read_pause;
  logic [NUM_LANES-1:0]            memc__dma__write_ready;
  logic [NUM_LANES-1:0]            memc__dma__read_ready;
  logic [DATA_WIDTH-1:0]           memc__dma__read_data;
  logic [NUM_LANES-1:0]            memc__dma__read_data_valid;
  logic                            arb__mem__req;
  logic                            arb__mem__we;
  logic [ADDR_WIDTH-1:0]           arb__mem__addr;
  logic [DATA_WIDTH-1:0]           arb__mem__wdata;
  logic                            mem__arb__ready;
  logic [DATA_WIDTH-1:0]           mem__arb__rdata;
  logic                            mem__arb__rdata_valid;
  logic                            arb__err;

  modport slave (
    input  dma__memc__write_valid, dma__memc__write_address, dma__memc__write_data,
    input  dma__memc__read_valid, dma__memc__read_address, dma__memc__read_pause,
    output memc__dma__write_ready, memc__dma__read_ready,
    output memc__dma__read_data, memc__dma__read_data_valid,
    output arb__mem__req, arb__mem__we, arb__mem__addr, arb__mem__wdata,
    input  mem__arb__ready, mem__arb__rdata, mem__arb__rdata_valid,
    output arb__err
  );

  modport master (
    output dma__memc__write_valid, dma__memc__write_address, dma__memc__write_data,
    output dma__memc__read_valid, dma__memc__read_address, dma__memc__read_pause,
    input  memc__dma__write_ready, memc__dma__read_ready,
    input  memc__dma__read_data, memc__dma__read_data_valid,
    input  arb__mem__req, arb__mem__we, arb__mem__addr, arb__mem__wdata,
    output mem__arb__ready, mem__arb__rdata, mem__arb__rdata_valid,
    input  arb__err
  );
endinterface

// File: rtl/dma_mem_arbiter.sv
// Round-robin arbiter sharing one PE memory port among DMA lanes; in-order read tag FIFO
// steers returned read data back to the lane that issued the read.
module dma_mem_arbiter #(
  parameter int NUM_LANES    = 4,
  parameter int ADDR_WIDTH   = 24,
  parameter int DATA_WIDTH   = 32,
  parameter int RD_TAG_DEPTH = 8
) (
  input logic             clk,
  input logic             reset_poweron,
  dma_mem_arbiter_if.slave bus
);
  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int PW = $clog2(RD_TAG_DEPTH);
  localparam int CW = PW + 1;

  logic [LW-1:0]        rr_q, rr_d;
  logic [NUM_LANES-1:0] pref_q, pref_d;     // 1 = read goes next when both ops pend
  logic [LW-1:0]        tag_mem_q [RD_TAG_DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 hold_q, hold_d;
  logic [LW-1:0]        hold_lane_q, hold_lane_d;
  logic                 hold_we_q, hold_we_d;
  logic                 err_q, err_d;

  logic [NUM_LANES-1:0] wr_elig, rd_elig, elig;
  logic                 tags_full;
  logic                 scan_found, hold_live, req_raw, gnt_we, both, xfer, push, pop;
  logic [LW-1:0]        scan_lane, gnt_lane, head_lane;
  logic [NUM_LANES-1:0] gnt_onehot, head_onehot;

  assign tags_full = (cnt_q == CW'(RD_TAG_DEPTH));

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_elig
      assign wr_elig[gi] = bus.dma__memc__write_valid[gi];
      assign rd_elig[gi] = bus.dma__memc__read_valid[gi] & ~bus.dma__memc__read_pause[gi] & ~tags_full;
      assign elig[gi]    = wr_elig[gi] | rd_elig[gi];
    end
  endgenerate

  always_comb begin
    scan_found = 1'b0;
    scan_lane  = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (!scan_found && elig[(int'(rr_q) + k) % NUM_LANES]) begin
        scan_found = 1'b1;
        scan_lane  = LW'((int'(rr_q) + k) % NUM_LANES);
      end
    end
  end

  // A request stalled by the memory stays granted until it transfers, even if
  // a return frees a tag slot and makes an earlier lane eligible meanwhile.
  assign hold_live  = hold_q & (hold_we_q ? wr_elig[hold_lane_q] : rd_elig[hold_lane_q]);
  assign gnt_lane   = hold_live ? hold_lane_q : scan_lane;
  assign both       = wr_elig[gnt_lane] & rd_elig[gnt_lane];
  assign gnt_we     = hold_live ? hold_we_q : (both ? ~pref_q[gnt_lane] : wr_elig[gnt_lane]);
  assign req_raw    = hold_live | scan_found;
  assign xfer       = req_raw & bus.mem__arb__ready;
  assign push       = xfer & ~gnt_we;
  assign pop        = bus.mem__arb__rdata_valid & (cnt_q != '0);
  assign head_lane  = tag_mem_q[rd_ptr_q];
  assign gnt_onehot = NUM_LANES'(1) << gnt_lane;
  assign head_onehot = NUM_LANES'(1) << head_lane;

  // Outputs are forced low while reset is asserted; state logic uses the raw grant.
  assign bus.arb__mem__req   = req_raw & reset_poweron;
  assign bus.arb__mem__we    = req_raw & reset_poweron & gnt_we;
  assign bus.arb__mem__addr  = (req_raw & reset_poweron) ?
      (gnt_we ? bus.dma__memc__write_address[int'(gnt_lane)*ADDR_WIDTH +: ADDR_WIDTH]
              : bus.dma__memc__read_address[int'(gnt_lane)*ADDR_WIDTH +: ADDR_WIDTH]) : '0;
  assign bus.arb__mem__wdata = (req_raw & reset_poweron & gnt_we) ?
      bus.dma__memc__write_data[int'(gnt_lane)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign bus.memc__dma__write_ready    = (xfer & reset_poweron & gnt_we)  ? gnt_onehot : '0;
  assign bus.memc__dma__read_ready     = (xfer & reset_poweron & ~gnt_we) ? gnt_onehot : '0;
  assign bus.memc__dma__read_data_valid = pop ? head_onehot : '0;
  assign bus.memc__dma__read_data      = pop ? bus.mem__arb__rdata : '0;
  assign bus.arb__err                  = err_q;

  always_comb begin
    rr_d        = rr_q;
    pref_d      = pref_q;
    hold_d      = req_raw & ~bus.mem__arb__ready;
    hold_lane_d = gnt_lane;
    hold_we_d   = gnt_we;
    wr_ptr_d    = wr_ptr_q + PW'(push);
    rd_ptr_d    = rd_ptr_q + PW'(pop);
    cnt_d       = cnt_q + CW'(push) - CW'(pop);
    err_d       = err_q | (bus.mem__arb__rdata_valid & (cnt_q == '0));
    if (xfer) begin
      rr_d = (int'(gnt_lane) == NUM_LANES - 1) ? '0 : gnt_lane + LW'(1);
      if (both) begin
        pref_d[gnt_lane] = ~pref_q[gnt_lane];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      rr_q        <= '0;
      pref_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      hold_q      <= 1'b0;
      hold_lane_q <= '0;
      hold_we_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      rr_q        <= rr_d;
      pref_q      <= pref_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      hold_lane_q <= hold_lane_d;
      hold_we_q   <= hold_we_d;
      err_q       <= err_d;
    end
  end

  // Tag storage needs no reset: entries are only read while the count says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem_q[wr_ptr_q] <= gnt_lane;
    end
  end
endmodule

// File: tb/tb_dma_mem_arbiter.sv
// Self-checking bench for dma_mem_arbiter: directed vector table, hand-written corner
// sequences, then randomized traffic against a queue-based reference model.
module tb_dma_mem_arbiter;
  logic clk = 1'b0;
  logic reset_poweron;
  always #5 clk = ~clk;

  dma_mem_arbiter_if #(.NUM_LANES(4), .ADDR_WIDTH(24), .DATA_WIDTH(32)) bus ();

  dma_mem_arbiter #(.NUM_LANES(4), .ADDR_WIDTH(24), .DATA_WIDTH(32), .RD_TAG_DEPTH(8)) dut (
    .clk(clk),
    .reset_poweron(reset_poweron),
    .bus(bus.slave)
  );

  int n_checks = 0;
  int n_fail = 0;

  logic [3:0]  wv, rv, rp;
  logic        mr, rvin;
  logic [31:0] rdin;
  logic [23:0] waddr [4];
  logic [23:0] raddr [4];
  logic [31:0] wdat  [4];

  typedef struct {
    logic [3:0]  wv, rv, rp;
    logic        mr, rvin;
    logic [31:0] rd;
    logic        ereq, ewe;
    int          elane;
    logic [3:0]  ewr, erd, erdv;
    logic [31:0] erdata;
  } vec_t;
  vec_t tbl [$];

  function automatic vec_t mk(input logic [3:0] w, r, input logic m, input logic ri, input logic [31:0] d,
                              input logic eq, ew, input int el, input logic [3:0] ewr, erd, erdv,
                              input logic [31:0] erdata);
    vec_t v;
    v.wv = w; v.rv = r; v.rp = 4'b0; v.mr = m; v.rvin = ri; v.rd = d;
    v.ereq = eq; v.ewe = ew; v.elane = el; v.ewr = ewr; v.erd = erd; v.erdv = erdv; v.erdata = erdata;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    bus.dma__memc__write_valid = wv;
    bus.dma__memc__read_valid  = rv;
    bus.dma__memc__read_pause  = rp;
    bus.mem__arb__ready        = mr;
    bus.mem__arb__rdata_valid  = rvin;
    bus.mem__arb__rdata        = rdin;
    for (int i = 0; i < 4; i++) begin
      bus.dma__memc__write_address[i*24 +: 24] = waddr[i];
      bus.dma__memc__read_address[i*24 +: 24]  = raddr[i];
      bus.dma__memc__write_data[i*32 +: 32]    = wdat[i];
    end
  endtask

  // Inputs are applied just after a rising edge; outputs are sampled at the falling edge.
  task automatic to_sample();
    drive();
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wv = '0; rv = '0; rp = '0; mr = 1'b1; rvin = 1'b0; rdin = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    drive();
    reset_poweron = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_poweron = 1'b1;
  endtask

  task automatic chk_grant(input string tag, input logic eq, input logic ew, input int el);
    chk({tag, ".req"}, 64'(bus.arb__mem__req), 64'(eq));
    if (eq) begin
      chk({tag, ".we"}, 64'(bus.arb__mem__we), 64'(ew));
      chk({tag, ".addr"}, 64'(bus.arb__mem__addr), 64'(ew ? waddr[el] : raddr[el]));
      chk({tag, ".wdata"}, 64'(bus.arb__mem__wdata), 64'(ew ? wdat[el] : 32'h0));
    end
  endtask

  // Reference-model state for the random phase
  int          m_rr;
  logic [3:0]  m_pref_rd;
  int          m_tags [$];
  logic        m_err, m_stall;
  int          m_stall_lane;
  logic        m_stall_we;

  initial begin
    for (int i = 0; i < 4; i++) begin
      waddr[i] = 24'h000100 + 24'(i);
      raddr[i] = 24'h000200 + 24'(i);
      wdat[i]  = 32'hA000_0000 + 32'(i);
    end

    // Reset with every request asserted: all outputs quiet
    wv = 4'hF; rv = 4'hF; rp = '0; mr = 1'b1; rvin = 1'b1; rdin = 32'hDEAD_BEEF;
    reset_poweron = 1'b0;
    drive();
    @(posedge clk); @(negedge clk);
    chk("rst.req", 64'(bus.arb__mem__req), 64'h0);
    chk("rst.we", 64'(bus.arb__mem__we), 64'h0);
    chk("rst.addr", 64'(bus.arb__mem__addr), 64'h0);
    chk("rst.wdata", 64'(bus.arb__mem__wdata), 64'h0);
    chk("rst.wr_ready", 64'(bus.memc__dma__write_ready), 64'h0);
    chk("rst.rd_ready", 64'(bus.memc__dma__read_ready), 64'h0);
    chk("rst.rdv", 64'(bus.memc__dma__read_data_valid), 64'h0);
    chk("rst.rdata", 64'(bus.memc__dma__read_data), 64'h0);
    chk("rst.err", 64'(bus.arb__err), 64'h0);
    rvin = 1'b0; drive();
    reset_poweron = 1'b1;
    #1;
    chk_grant("rel", 1'b1, 1'b1, 0);
    chk("rel.wr_ready", 64'(bus.memc__dma__write_ready), 64'h1);
    $display("reset release: first grant lane 0 write");
    do_reset();

    // Directed table starting from a fresh reset
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(4'hF, 4'h0, 1, 0, 0, 1, 1, i % 4, 4'(1 << (i % 4)), 4'h0, 4'h0, 0));
    tbl.push_back(mk(4'h4, 4'h4, 1, 0, 0, 1, 1, 2, 4'h4, 4'h0, 4'h0, 0));
    tbl.push_back(mk(4'h4, 4'h4, 1, 0, 0, 1, 0, 2, 4'h0, 4'h4, 4'h0, 0));
    tbl.push_back(mk(4'h4, 4'h4, 1, 0, 0, 1, 1, 2, 4'h4, 4'h0, 4'h0, 0));
    tbl.push_back(mk(4'h4, 4'h4, 1, 0, 0, 1, 0, 2, 4'h0, 4'h4, 4'h0, 0));
    tbl.push_back(mk(4'h0, 4'h0, 1, 1, 32'h11, 0, 0, 0, 4'h0, 4'h0, 4'h4, 32'h11));
    tbl.push_back(mk(4'h0, 4'h0, 1, 1, 32'h22, 0, 0, 0, 4'h0, 4'h0, 4'h4, 32'h22));
    tbl.push_back(mk(4'h0, 4'hD, 1, 0, 0, 1, 0, 3, 4'h0, 4'h8, 4'h0, 0));
    tbl.push_back(mk(4'h0, 4'h5, 1, 0, 0, 1, 0, 0, 4'h0, 4'h1, 4'h0, 0));
    tbl.push_back(mk(4'h0, 4'h4, 1, 0, 0, 1, 0, 2, 4'h0, 4'h4, 4'h0, 0));
    tbl.push_back(mk(4'h0, 4'h0, 1, 1, 32'hD0, 0, 0, 0, 4'h0, 4'h0, 4'h8, 32'hD0));
    tbl.push_back(mk(4'h0, 4'h0, 1, 1, 32'hD1, 0, 0, 0, 4'h0, 4'h0, 4'h1, 32'hD1));
    tbl.push_back(mk(4'h0, 4'h0, 1, 1, 32'hD2, 0, 0, 0, 4'h0, 4'h0, 4'h4, 32'hD2));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(4'h0, 4'h2, 0, 0, 0, 1, 0, 1, 4'h0, 4'h0, 4'h0, 0));
    tbl.push_back(mk(4'h0, 4'h2, 1, 0, 0, 1, 0, 1, 4'h0, 4'h2, 4'h0, 0));
    tbl.push_back(mk(4'h0, 4'h1, 1, 1, 32'h55, 1, 0, 0, 4'h0, 4'h1, 4'h2, 32'h55));
    tbl.push_back(mk(4'h0, 4'h0, 1, 1, 32'h66, 0, 0, 0, 4'h0, 4'h0, 4'h1, 32'h66));

    foreach (tbl[i]) begin
      wv = tbl[i].wv; rv = tbl[i].rv; rp = tbl[i].rp; mr = tbl[i].mr; rvin = tbl[i].rvin; rdin = tbl[i].rd;
      to_sample();
      $display("vec %0d: wv=%b rv=%b mr=%b ret=%b -> req=%b we=%b wr=%b rd=%b rdv=%b", i, wv, rv, mr, rvin,
               bus.arb__mem__req, bus.arb__mem__we, bus.memc__dma__write_ready,
               bus.memc__dma__read_ready, bus.memc__dma__read_data_valid);
      chk_grant($sformatf("vec%0d", i), tbl[i].ereq, tbl[i].ewe, tbl[i].elane);
      chk($sformatf("vec%0d.wr_ready", i), 64'(bus.memc__dma__write_ready), 64'(tbl[i].ewr));
      chk($sformatf("vec%0d.rd_ready", i), 64'(bus.memc__dma__read_ready), 64'(tbl[i].erd));
      chk($sformatf("vec%0d.rdv", i), 64'(bus.memc__dma__read_data_valid), 64'(tbl[i].erdv));
      if (tbl[i].erdv != 4'h0)
        chk($sformatf("vec%0d.rdata", i), 64'(bus.memc__dma__read_data), 64'(tbl[i].erdata));
      chk($sformatf("vec%0d.err", i), 64'(bus.arb__err), 64'h0);
      next_cycle();
    end

    // Return with no outstanding read: dropped, error sticks until reset
    idle_inputs(); rvin = 1'b1; rdin = 32'hBAD0;
    to_sample();
    chk("spur.rdv", 64'(bus.memc__dma__read_data_valid), 64'h0);
    next_cycle();
    idle_inputs(); wv = 4'h2;
    for (int i = 0; i < 3; i++) begin
      to_sample();
      chk($sformatf("err.hold%0d", i), 64'(bus.arb__err), 64'h1);
      next_cycle();
    end
    $display("spurious return: err=%b", bus.arb__err);
    do_reset();
    to_sample();
    chk("err.cleared", 64'(bus.arb__err), 64'h0);
    next_cycle();

    // Tag FIFO full: lane 1 reads blocked, lane 3 write still served
    do_reset();
    idle_inputs(); rv = 4'h2;
    for (int i = 0; i < 8; i++) begin
      to_sample();
      chk($sformatf("fill%0d.rd_ready", i), 64'(bus.memc__dma__read_ready), 64'h2);
      next_cycle();
    end
    to_sample();
    chk("full.req", 64'(bus.arb__mem__req), 64'h0);
    chk("full.rd_ready", 64'(bus.memc__dma__read_ready), 64'h0);
    next_cycle();
    wv = 4'h8;
    to_sample();
    chk_grant("full.w3", 1'b1, 1'b1, 3);
    chk("full.wr_ready", 64'(bus.memc__dma__write_ready), 64'h8);
    chk("full.rd_ready2", 64'(bus.memc__dma__read_ready), 64'h0);
    next_cycle();
    wv = 4'h0; rvin = 1'b1; rdin = 32'h77;
    to_sample();
    chk("full.ret_rdv", 64'(bus.memc__dma__read_data_valid), 64'h2);
    chk("full.ret_rd_ready", 64'(bus.memc__dma__read_ready), 64'h0);
    next_cycle();
    rvin = 1'b0;
    to_sample();
    chk("full.reissue", 64'(bus.memc__dma__read_ready), 64'h2);
    next_cycle();
    $display("tag fifo full/drain sequence done");
    rv = 4'h0; rvin = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rdin = 32'h700 + 32'(i);
      to_sample();
      chk($sformatf("drain%0d.rdv", i), 64'(bus.memc__dma__read_data_valid), 64'h2);
      next_cycle();
    end
    rvin = 1'b0;
    to_sample();
    chk("drain.err", 64'(bus.arb__err), 64'h0);
    next_cycle();

    // Reset mid-flight: the in-flight read's later return raises err
    do_reset();
    rv = 4'h2;
    to_sample();
    chk("mid.rd_ready", 64'(bus.memc__dma__read_ready), 64'h2);
    next_cycle();
    rv = 4'h0; drive();
    #2 reset_poweron = 1'b0;
    @(posedge clk); #1;
    reset_poweron = 1'b1;
    rvin = 1'b1; rdin = 32'h99;
    to_sample();
    chk("mid.rdv", 64'(bus.memc__dma__read_data_valid), 64'h0);
    next_cycle();
    rvin = 1'b0;
    to_sample();
    chk("mid.err", 64'(bus.arb__err), 64'h1);
    next_cycle();

    // Randomized traffic against the reference model
    do_reset();
    m_rr = 0; m_pref_rd = '0; m_tags.delete(); m_err = 1'b0; m_stall = 1'b0;
    m_stall_lane = 0; m_stall_we = 1'b0;
    for (int c = 0; c < 400; c++) begin
      logic [3:0] re, el;
      logic       found, gwe;
      int         g;
      if (!m_stall) begin
        wv = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
        rv = 4'($urandom_range(0, 15));
        rp = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
        for (int i = 0; i < 4; i++) begin
          waddr[i] = 24'($urandom); raddr[i] = 24'($urandom); wdat[i] = $urandom;
        end
      end
      mr = ($urandom_range(0, 3) != 0);
      rvin = (m_tags.size() > 0) && ($urandom_range(0, 9) < 3);
      rdin = $urandom;
      for (int i = 0; i < 4; i++) begin
        re[i] = rv[i] & ~rp[i] & (m_tags.size() < 8);
        el[i] = wv[i] | re[i];
      end
      found = 1'b0; g = 0; gwe = 1'b0;
      if (m_stall) begin
        found = 1'b1; g = m_stall_lane; gwe = m_stall_we;
      end else begin
        for (int k = 0; k < 4; k++) begin
          if (!found && el[(m_rr + k) % 4]) begin
            found = 1'b1; g = (m_rr + k) % 4;
          end
        end
        if (found) gwe = (wv[g] & re[g]) ? ~m_pref_rd[g] : wv[g];
      end
      to_sample();
      chk_grant($sformatf("rnd%0d", c), found, gwe, g);
      chk($sformatf("rnd%0d.wr_ready", c), 64'(bus.memc__dma__write_ready),
          64'((found & mr & gwe) ? (4'b0001 << g) : 4'b0));
      chk($sformatf("rnd%0d.rd_ready", c), 64'(bus.memc__dma__read_ready),
          64'((found & mr & ~gwe) ? (4'b0001 << g) : 4'b0));
      chk($sformatf("rnd%0d.rdv", c), 64'(bus.memc__dma__read_data_valid),
          64'((rvin && m_tags.size() > 0) ? (4'b0001 << m_tags[0]) : 4'b0));
      if (rvin && m_tags.size() > 0)
        chk($sformatf("rnd%0d.rdata", c), 64'(bus.memc__dma__read_data), 64'(rdin));
      chk($sformatf("rnd%0d.err", c), 64'(bus.arb__err), 64'(m_err));
      if (found && mr)
        $display("rnd %0d: lane %0d %s addr=%06h", c, g, gwe ? "write" : "read", bus.arb__mem__addr);
      if (rvin) begin
        if (m_tags.size() == 0) m_err = 1'b1;
        else void'(m_tags.pop_front());
      end
      if (found && mr) begin
        m_rr = (g + 1) % 4;
        if (wv[g] & re[g]) m_pref_rd[g] = ~m_pref_rd[g];
        if (!gwe) m_tags.push_back(g);
      end
      m_stall = found & ~mr;
      m_stall_lane = g;
      m_stall_we = gwe;
      next_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
